// File: rtl/pattern_scan_pkg.sv
// Shared types and default parameters for the pattern scan arbiter.
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } scan_state_e;

   localparam int unsigned WORD_W_DEF  = 8;
   localparam int unsigned PAT_W_DEF   = 4;
   localparam logic [3:0]  PATTERN_DEF = 4'b1011;
   localparam int unsigned CNT_W_DEF   = 4;

   // The count must hold the largest overlapping match total without wrapping.
   function automatic bit cnt_w_legal(input int unsigned cnt_w,
                                      input int unsigned word_w,
                                      input int unsigned pat_w);
      return (pat_w >= 32'd2) && (pat_w <= word_w) &&
             ((64'd1 << cnt_w) > 64'(word_w - pat_w + 32'd1));
   endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Serial matcher: keeps the last PAT_W-1 bits and flags when the incoming bit
// completes PATTERN (earliest bit in the pattern MSB).
module pattern_match_core
   import pattern_scan_pkg::*;
#(
   parameter int unsigned      PAT_W   = PAT_W_DEF,
   parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic shift_en,
   input  logic bit_in,
   output logic match
);

   localparam int unsigned SEEN_W = $clog2(PAT_W);

   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [SEEN_W-1:0] seen_q, seen_d;
   logic [PAT_W-1:0]  window_s;
   logic              full_s;

   assign window_s = {hist_q, bit_in};
   assign full_s   = (seen_q == SEEN_W'(PAT_W - 1));

   // Window update and match compare; bits_seen saturates once a full pattern fits.
   always_comb begin
      hist_d = hist_q;
      seen_d = seen_q;
      match  = 1'b0;
      if (clr) begin
         hist_d = '0;
         seen_d = '0;
      end else if (shift_en) begin
         match  = (window_s == PATTERN) && full_s;
         hist_d = window_s[PAT_W-2:0];
         if (!full_s) begin
            seen_d = seen_q + SEEN_W'(1);
         end else begin
            seen_d = seen_q;
         end
      end else begin
         hist_d = hist_q;
         seen_d = seen_q;
      end
   end

   // Window state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q <= '0;
         seen_q <= '0;
      end else begin
         hist_q <= hist_d;
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/pattern_scan_arbiter.sv
// Round-robin front-end sharing one serial pattern matcher between two requesters.
// Define SCAN_LSB_FIRST_EN to shift words LSB first (default: MSB first).
module pattern_scan_arbiter
   import pattern_scan_pkg::*;
#(
   parameter int unsigned      WORD_W  = WORD_W_DEF,
   parameter int unsigned      PAT_W   = PAT_W_DEF,
   parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
   parameter int unsigned      CNT_W   = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   input  logic [WORD_W-1:0] req_data0,
   input  logic [WORD_W-1:0] req_data1,
   output logic [1:0]        req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WORD_W-1:0] rsp_data,
   output logic [CNT_W-1:0]  rsp_count,
   output logic              busy,
   output logic              bit_out,
   output logic              hit
);

   localparam int unsigned BC_W = $clog2(WORD_W);

   if (!cnt_w_legal(CNT_W, WORD_W, PAT_W)) begin : g_bad_cfg
      $error("pattern_scan_arbiter: illegal PAT_W/CNT_W for WORD_W");
   end

   scan_state_e       state_q, state_d;
   logic              last_q, last_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              id_q, id_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic              bit_out_q, bit_out_d;
   logic              hit_q;

   logic [1:0]        rr_grant_s, grant_s;
   logic              clr_s, shift_s, match_s, scan_bit_s;
   logic [WORD_W-1:0] sreg_shift_s;

`ifdef SCAN_LSB_FIRST_EN
   assign scan_bit_s   = sreg_q[0];
   assign sreg_shift_s = {1'b0, sreg_q[WORD_W-1:1]};
`else
   assign scan_bit_s   = sreg_q[WORD_W-1];
   assign sreg_shift_s = {sreg_q[WORD_W-2:0], 1'b0};
`endif

   // With both valid, the requester that was not served last wins.
   assign rr_grant_s[0] = req_valid[0] & (~req_valid[1] | last_q);
   assign rr_grant_s[1] = req_valid[1] & (~req_valid[0] | ~last_q);

   pattern_match_core #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_s),
      .shift_en (shift_s),
      .bit_in   (scan_bit_s),
      .match    (match_s)
   );

   // FSM next state, datapath capture and shift sequencing.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      sreg_d    = sreg_q;
      data_d    = data_q;
      id_d      = id_q;
      count_d   = count_q;
      bcnt_d    = bcnt_q;
      bit_out_d = bit_out_q;
      grant_s   = 2'b00;
      clr_s     = 1'b0;
      shift_s   = 1'b0;
      case (state_q)
         IDLE: begin
            grant_s = rr_grant_s;
            if (|grant_s) begin
               clr_s   = 1'b1;
               id_d    = grant_s[1];
               data_d  = grant_s[1] ? req_data1 : req_data0;
               sreg_d  = grant_s[1] ? req_data1 : req_data0;
               count_d = '0;
               bcnt_d  = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            shift_s   = 1'b1;
            sreg_d    = sreg_shift_s;
            bit_out_d = scan_bit_s;
            count_d   = count_q + CNT_W'(match_s);
            if (bcnt_q == BC_W'(WORD_W - 1)) begin
               bcnt_d  = '0;
               state_d = RESP;
            end else begin
               bcnt_d  = bcnt_q + BC_W'(1);
               state_d = SHIFT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         sreg_q    <= '0;
         data_q    <= '0;
         id_q      <= 1'b0;
         count_q   <= '0;
         bcnt_q    <= '0;
         bit_out_q <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         sreg_q    <= sreg_d;
         data_q    <= data_d;
         id_q      <= id_d;
         count_q   <= count_d;
         bcnt_q    <= bcnt_d;
         bit_out_q <= bit_out_d;
         hit_q     <= match_s;
      end
   end

   assign req_ready = grant_s & {2{rst_n}};
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_count = count_q;
   assign bit_out   = bit_out_q;
   assign hit       = hit_q;

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Randomized scoreboard bench for pattern_scan_arbiter with a word-level reference model.
module tb_pattern_scan_arbiter;
   import pattern_scan_pkg::*;

   localparam int unsigned W = WORD_W_DEF;
   localparam int unsigned P = PAT_W_DEF;
   localparam int unsigned C = CNT_W_DEF;
   localparam logic [P-1:0] PAT = PATTERN_DEF;
`ifdef SCAN_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [W-1:0]  req_data0, req_data1;
   logic [1:0]    req_ready;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0]  rsp_data;
   logic [C-1:0]  rsp_count;
   logic          busy, bit_out, hit;

   pattern_scan_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_count (rsp_count),
      .busy      (busy),
      .bit_out   (bit_out),
      .hit       (hit)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [W-1:0] data;
      int           cnt;
      int           t;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   done_cnt = 0;
   int   last_m = 1;
   int   hits = 0;
   int   tmo = 0;
   bit   seen_v = 1'b0;
   bit   rst_prev = 1'b1;
   bit   drv_done = 1'b0;
   bit   fin_done = 1'b0;

   // Bit at time position t of the serial stream for word w.
   function automatic logic stream_bit(input logic [W-1:0] w, input int t);
      return LSB_FIRST ? w[t] : w[W-1-t];
   endfunction

   // Count every (possibly overlapping) window of P consecutive bits equal to PAT.
   function automatic int ref_count(input logic [W-1:0] w);
      int n = 0;
      for (int s = 0; s <= int'(W - P); s++) begin
         bit ok = 1'b1;
         for (int k = 0; k < int'(P); k++) begin
            if (stream_bit(w, s + k) != PAT[P-1-k]) ok = 1'b0;
         end
         if (ok) n++;
      end
      return n;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: predicts grants and pushes expectations, pops on each response.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("ready_in_reset", int'(req_ready), 0);
         exp_q.delete();
         acc_cnt  = done_cnt;
         last_m   = 1;
         hits     = 0;
         seen_v   = 1'b0;
         rst_prev = 1'b0;
      end else begin
         bit idle;
         int exp_g;
         if (!rst_prev) begin
            chk("post_rst_rsp_valid", int'(rsp_valid), 0);
            chk("post_rst_rsp_id", int'(rsp_id), 0);
            chk("post_rst_rsp_data", int'(rsp_data), 0);
            chk("post_rst_rsp_count", int'(rsp_count), 0);
            chk("post_rst_bit_out", int'(bit_out), 0);
            chk("post_rst_hit", int'(hit), 0);
         end
         rst_prev = 1'b1;
         idle = (acc_cnt == done_cnt);
         chk("busy", int'(busy), idle ? 0 : 1);
         if (idle) begin
            if (req_valid == 2'b11) exp_g = (last_m == 1) ? 1 : 2;
            else                    exp_g = int'(req_valid);
            chk("grant", int'(req_ready), exp_g);
            if (exp_g != 0) begin
               exp_t e;
               e.id   = (exp_g == 2) ? 1 : 0;
               e.data = (exp_g == 2) ? req_data1 : req_data0;
               e.cnt  = ref_count(e.data);
               e.t    = cyc;
               exp_q.push_back(e);
               acc_cnt++;
            end
         end else begin
            chk("ready_not_idle", int'(req_ready), 0);
         end
         if (hit) hits++;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rsp", 1, 0);
            end else begin
               exp_t e;
               e = exp_q[0];
               if (!seen_v) begin
                  chk("latency", cyc - e.t, int'(W) + 1);
                  chk("last_bit_out", int'(bit_out), int'(stream_bit(e.data, int'(W) - 1)));
                  seen_v = 1'b1;
               end
               chk("rsp_id", int'(rsp_id), e.id);
               chk("rsp_data", int'(rsp_data), int'(e.data));
               chk("rsp_count", int'(rsp_count), e.cnt);
               if (rsp_ready) begin
                  chk("hit_pulses", hits, e.cnt);
                  hits   = 0;
                  last_m = e.id;
                  done_cnt++;
                  void'(exp_q.pop_front());
                  seen_v = 1'b0;
               end
            end
         end else if (exp_q.size() != 0 && (cyc - exp_q[0].t) > int'(W) + 1) begin
            chk("rsp_late", 1, 0);
         end
      end
      if (drv_done && !fin_done) begin
         chk("outstanding_at_end", exp_q.size(), 0);
         chk("driver_timeouts", tmo, 0);
         fin_done = 1'b1;
      end
   end

   task automatic wait_idle(input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < lim);
      if (busy) tmo++;
   endtask

   task automatic send(input int id, input logic [W-1:0] w);
      int n = 0;
      @(posedge clk);
      #1;
      if (id == 0) req_data0 = w;
      else         req_data1 = w;
      req_valid = (id == 0) ? 2'b01 : 2'b10;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[id] && n < 40);
      if (!req_ready[id]) tmo++;
      @(posedge clk);
      #1 req_valid = 2'b00;
   endtask

   // Stimulus driver.
   initial begin
      int n;
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_data0 = 8'hBB;
      req_data1 = 8'hB6;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      // Both requesters held valid: expect A, B, A.
      repeat (3 * (W + 2) + 1) @(posedge clk);
      #1 req_valid = 2'b00;
      wait_idle(40);

      send(0, 8'h00);
      wait_idle(40);
      send(1, 8'hB6);
      wait_idle(40);
      send(0, 8'h0D);
      wait_idle(40);

      // Stall in RESP with a request pending from the other side.
      rsp_ready = 1'b0;
      send(0, W'($urandom));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 30);
      if (!rsp_valid) tmo++;
      @(posedge clk);
      #1 req_valid = 2'b10;
      req_data1 = W'($urandom);
      repeat (20) @(posedge clk);
      #1 rsp_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[1] && n < 10);
      if (!req_ready[1]) tmo++;
      @(posedge clk);
      #1 req_valid = 2'b00;
      wait_idle(40);

      // Reset during the fourth SHIFT cycle, then a clean rescan.
      send(0, 8'hB3);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(0, 8'hBB);
      wait_idle(40);

      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         req_valid = 2'($urandom_range(0, 3));
         req_data0 = W'($urandom);
         req_data1 = W'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      rsp_ready = 1'b1;
      wait_idle(40);

      drv_done = 1'b1;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pattern_scan_arbiter.md
# pattern_scan_arbiter

- Shares one serial pattern-match engine between two word-level requesters.
- Arbitrates round-robin between the requesters and captures the granted parallel word.
- Shifts the word one bit per clock through the matcher, counting overlapping occurrences of a fixed bit pattern.
- Returns the count with a valid/ready response; this is the sequencing front-end for the serial pattern detectors in the lab design.

## Interface
- WORD_W, 8, bits per request word
- PAT_W, 4, pattern length in bits; requires 2 ≤ PAT_W ≤ WORD_W
- PATTERN, 4'b1011, pattern to detect; compared with the oldest bit in the MSB position
- CNT_W, 4, count width; requires 2^CNT_W > WORD_W-PAT_W+1
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_data0  in  WORD_W  word from requester 0
- req_data1  in  WORD_W  word from requester 1
- req_ready  out  2  one-hot grant; the handshake is req_valid[i] & req_ready[i]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  1  requester index of the result
- rsp_data  out  WORD_W  echo of the scanned word
- rsp_count  out  CNT_W  number of matches in the word
- busy  out  1  high in SHIFT and RESP
- bit_out  out  1  registered copy of the last bit shifted (serial monitor)
- hit  out  1  one-cycle pulse, registered, one cycle after the completing bit

## Operation
- The FSM has three states: IDLE, SHIFT and RESP.
- IDLE:
  - req_ready is driven combinationally to the round-robin winner among the asserted req_valid bits. The winner is the requester that is not the last-served one (pointer `last`) when both are valid; otherwise it is the single valid requester.
  - On a handshake: capture the word into a shift register, clear the match window, bit counter and count, record the id, and go to SHIFT.
  - req_ready is 0 in every state other than IDLE.
- SHIFT, one bit per cycle, WORD_W cycles:
  - The next bit b is the MSB of the shift register; it is inserted into the PAT_W-bit window.
  - match = ({win[PAT_W-2:0], b} == PATTERN) && (bits_seen ≥ PAT_W-1).
  - count += match.
  - Matches may overlap: the window is not cleared after a match.
  - After the WORD_W-th bit, go to RESP.
- RESP:
  - rsp_valid = 1 and rsp_id, rsp_data and rsp_count are held stable.
  - On rsp_valid & rsp_ready: set `last` to rsp_id and go to IDLE.
- Count arithmetic is unsigned. The maximum is WORD_W-PAT_W+1, so the count never wraps under legal parameters.
- Reset, including mid-SHIFT or mid-RESP, aborts the transaction without a response:
  - state goes to IDLE and `last` to 1, so requester 0 wins first;
  - all outputs go to 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_count, busy, bit_out and hit.

## Timing
- The handshake in cycle 0 is followed by SHIFT in cycles 1..WORD_W, and rsp_valid rises in cycle WORD_W+1. Latency is WORD_W+1 cycles when rsp_ready is held high.
- A response handshake in cycle t returns to IDLE in t+1, which can accept a new request in t+1. The minimum period is WORD_W+2 cycles per word.
- hit and bit_out lag the internal bit by one cycle. The final hit pulse therefore coincides with the first rsp_valid cycle.
- rsp_ready held low stalls indefinitely in RESP; no request is accepted meanwhile.
- req_valid changes while not in IDLE are ignored.

## Configuration
- SCAN_LSB_FIRST_EN:
  - Defined: words are shifted LSB first.
  - Undefined (default): words are shifted MSB first.
- Pattern orientation is unchanged either way: the PATTERN MSB is always the earliest bit in time.

## Structure
- Package pattern_scan_pkg holds:
  - the state enum (IDLE/SHIFT/RESP);
  - the default WORD_W, PAT_W, PATTERN and CNT_W constants;
  - a helper function for the CNT_W legality check.
- One sub-module, pattern_match_core, holds the window, the bits_seen counter and the match compare. Its ports are clk, rst_n, clr, shift_en, bit_in and match.
- The arbiter, FSM, shift register and counter live in the top level.

## Test plan
- Req0 = 8'b1011_1011 with rsp_ready = 1 -> rsp_valid in cycle 9, rsp_id = 0, rsp_count = 2, and hit pulses twice.
- Overlap: req1 = 8'b1011_0110 -> rsp_count = 2 and rsp_id = 1; req0 = 8'h00 -> rsp_count = 0 with no hit pulses.
- Both req_valid held from reset with words A and B -> A served first, B second, then A again; req_ready is never 2'b11.
- rsp_ready held low for 20 cycles -> rsp_valid and rsp_count stay stable, req_ready stays 0, and the pending request is accepted in the cycle after the response handshake.
- rst_n low in SHIFT cycle 4 -> all outputs are 0 the next cycle and no response is produced; the next request is scanned from a clean window.
- With SCAN_LSB_FIRST_EN, 8'b0000_1101 -> count 1; without it -> count 0.
